rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Transaction sequencer for the external RTC's multiplexed address/data (AD) bus. It accepts one read or write request at a time from the register-access logic, latches the request, and drives the bus data path through a fixed sequence: address phase, turnaround, then data phase. It asserts `en_tim` to the CS/RD/WR/AD strobe-timing generator for the whole transaction, captures read data, and reports completion with a single-cycle `done` pulse.

## Interface
Parameters:
- `T_ADDR`, default 10: address-phase length in clocks; must be 1 to 255.
- `T_GAP`, default 2: turnaround length in clocks with the bus released; must be 1 to 255.
- `T_DATA`, default 10: data-phase length in clocks; must be 1 to 255.

Ports:
- `clkW`  in  1: the block's single clock; all logic is on the rising edge.
- `resetW`  in  1: reset, synchronous and active-high.
- `req`  in  1: request strobe; sampled only in IDLE.
- `rw`  in  1: transaction type; 1 = read, 0 = write.
- `addr`  in  8: RTC register address.
- `wdata`  in  8: write data.
- `ad_in`  in  8: AD bus input from the pad.
- `ad_out`  out  8: AD bus output value.
- `ad_oe`  out  1: AD output enable; 1 = drive the pad.
- `ad_sel`  out  1: 1 during the address phase, else 0.
- `en_tim`  out  1: enable to the strobe-timing generator.
- `busy`  out  1: 1 whenever the state is not IDLE.
- `done`  out  1: one-cycle completion pulse.
- `rdata`  out  8: last captured read data.

## Operation
- All outputs are registered. Reset drives every output to 0 (including `rdata`), the state to IDLE, and the phase counter to 0.
- Phase counter: 8 bits, cleared on every state entry, compared against the current phase's parameter minus 1.
- States and outputs:
  - IDLE: all outputs 0 except `rdata`, which holds. When `req`=1 at a clock edge, latch `rw`/`addr`/`wdata` and go to ADDR.
  - ADDR: `ad_oe`=1, `ad_out`=addr, `ad_sel`=1, `en_tim`=1. After T_ADDR cycles, go to GAP.
  - GAP: `ad_oe`=0, `ad_out`=0, `ad_sel`=0, `en_tim`=1. After T_GAP cycles, go to DATA.
  - DATA, write: `ad_oe`=1, `ad_out`=wdata.
  - DATA, read: `ad_oe`=0, `ad_out`=0.
  - DATA, both types: `en_tim`=1. After T_DATA cycles, go to DONE.
  - DONE: `done`=1, all other outputs as in IDLE. After one cycle, go to IDLE.
- `busy`=1 in ADDR, GAP, DATA and DONE.
- Read capture: on the clock edge that ends the last DATA cycle, load `ad_in` into `rdata`. Writes never modify `rdata`.
- `req` outside IDLE (including during DONE) is ignored, not queued. The requester must hold or re-assert `req` once `busy`=0.
- Input changes after acceptance have no effect; only the latched copies are used.
- `ad_oe` is 0 for at least T_GAP cycles between address drive and data drive, and is never 1 in IDLE or DONE.

## Timing
- Accept edge k (IDLE, `req`=1): ADDR outputs appear in cycle k+1.
- ADDR occupies cycles k+1 .. k+T_ADDR.
- GAP occupies the next T_GAP cycles.
- DATA occupies the next T_DATA cycles.
- `done`=1 in cycle k+T_ADDR+T_GAP+T_DATA+1. For read transactions, the new `rdata` is valid in that same cycle.
- Earliest next accept is the edge ending the first IDLE cycle after DONE. Back-to-back spacing is T_ADDR+T_GAP+T_DATA+2 edges.
- `en_tim` is high for exactly T_ADDR+T_GAP+T_DATA consecutive cycles per transaction.
- Reset mid-transaction: on the reset edge all outputs go to 0 in the following cycle and `done` is not pulsed. A read aborted this way leaves `rdata`=0.
- `req` and `resetW` high on the same edge: reset wins and the request is dropped.

## Test plan
- Write, default parameters: `addr`=0x21, `wdata`=0x45, accept at edge 0.
  -> `ad_oe`=1 with `ad_out`=0x21 and `ad_sel`=1 for cycles 1-10.
  -> `ad_oe`=0 for cycles 11-12.
  -> `ad_oe`=1 with `ad_out`=0x45 for cycles 13-22.
  -> `done`=1 in cycle 23; `rdata` unchanged; `busy` high for cycles 1-23.
- Read, default parameters: `addr`=0x0C, `ad_in`=0x5A during DATA.
  -> `ad_oe`=0 for cycles 11-22.
  -> `rdata`=0x5A and `done`=1 in cycle 23.
  -> `rdata` still 0x5A after a following write.
- `req` pulsed at cycles 5 and 23 during a transaction -> both ignored; exactly one `done` pulse; no second transaction starts.
- `resetW` asserted in cycle 15 of a read -> all outputs 0 from cycle 16, no `done`, `rdata`=0; a new `req` afterwards is accepted normally.
- T_ADDR=1, T_GAP=1, T_DATA=1, with `req` held high continuously -> `en_tim` high 3 cycles, `done` in cycle 4, next ADDR starting in cycle 6.
- `req` and `resetW` high on the same edge -> state stays IDLE, `busy`=0.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Address / turnaround / data sequencer for the external RTC's multiplexed AD bus.
// All outputs are registered and loaded with the values of the state being entered.
module rtc_bus_sequencer #(
    parameter int T_ADDR = 10,
    parameter int T_GAP  = 2,
    parameter int T_DATA = 10
) (
    input  logic       clkW,
    input  logic       resetW,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       en_tim,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [7:0] addrLast = 8'(T_ADDR - 1);
    localparam logic [7:0] gapLast  = 8'(T_GAP - 1);
    localparam logic [7:0] dataLast = 8'(T_DATA - 1);

    logic [2:0] state;
    logic [7:0] phaseCnt;
    logic       rwL;
    logic [7:0] wdataL;

    // The address is latched straight into ad_out, so only rw and wdata need copies.
    always_ff @(posedge clkW) begin
        if (state == IDLE && req) begin
            rwL    <= rw;
            wdataL <= wdata;
        end
    end

    always_ff @(posedge clkW) begin
        if (resetW) begin
            state    <= IDLE;
            phaseCnt <= 8'd0;
            ad_out   <= 8'd0;
            ad_oe    <= 1'b0;
            ad_sel   <= 1'b0;
            en_tim   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= ADDR;
                        phaseCnt <= 8'd0;
                        ad_oe    <= 1'b1;
                        ad_out   <= addr;
                        ad_sel   <= 1'b1;
                        en_tim   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ADDR: begin
                    if (phaseCnt == addrLast) begin
                        state    <= GAP;
                        phaseCnt <= 8'd0;
                        ad_oe    <= 1'b0;
                        ad_out   <= 8'd0;
                        ad_sel   <= 1'b0;
                    end else begin
                        phaseCnt <= phaseCnt + 8'd1;
                    end
                end
                GAP: begin
                    if (phaseCnt == gapLast) begin
                        state    <= DATA;
                        phaseCnt <= 8'd0;
                        ad_oe    <= ~rwL;
                        ad_out   <= rwL ? 8'd0 : wdataL;
                    end else begin
                        phaseCnt <= phaseCnt + 8'd1;
                    end
                end
                DATA: begin
                    if (phaseCnt == dataLast) begin
                        state    <= DONE;
                        phaseCnt <= 8'd0;
                        ad_oe    <= 1'b0;
                        ad_out   <= 8'd0;
                        en_tim   <= 1'b0;
                        done     <= 1'b1;
                        if (rwL) begin
                            rdata <= ad_in;
                        end
                    end else begin
                        phaseCnt <= phaseCnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    phaseCnt <= 8'd0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    phaseCnt <= 8'd0;
                    ad_out   <= 8'd0;
                    ad_oe    <= 1'b0;
                    ad_sel   <= 1'b0;
                    en_tim   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor compares them.
module tb_rtc_bus_sequencer;

    logic clkW = 1'b0;
    always #5 clkW = ~clkW;

    logic       resetW, req, rw;
    logic [7:0] addr, wdata, ad_in;
    logic [7:0] ad_out, rdata;
    logic       ad_oe, ad_sel, en_tim, busy, done;

    logic       resetW2, req2, rw2;
    logic [7:0] addr2, wdata2, ad_in2;
    logic [7:0] ad_out2, rdata2;
    logic       ad_oe2, ad_sel2, en_tim2, busy2, done2;

    rtc_bus_sequencer dut (
        .clkW(clkW), .resetW(resetW), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ad_sel(ad_sel), .en_tim(en_tim),
        .busy(busy), .done(done), .rdata(rdata)
    );

    rtc_bus_sequencer #(.T_ADDR(1), .T_GAP(1), .T_DATA(1)) dutFast (
        .clkW(clkW), .resetW(resetW2), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .ad_in(ad_in2), .ad_out(ad_out2), .ad_oe(ad_oe2), .ad_sel(ad_sel2), .en_tim(en_tim2),
        .busy(busy2), .done(done2), .rdata(rdata2)
    );

    typedef struct {
        int          cyc;
        logic [20:0] v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;

    always @(posedge clkW) cyc <= cyc + 1;

    // Field order: {ad_oe, ad_out, ad_sel, en_tim, busy, done, rdata}
    function automatic logic [20:0] mk(logic oe, logic [7:0] o, logic sel, logic en,
                                       logic bsy, logic dn, logic [7:0] rd);
        return {oe, o, sel, en, bsy, dn, rd};
    endfunction

    function automatic void pushExp(int id, int c, logic [20:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    // Queues one record per cycle from the first ADDR cycle through the IDLE cycle after DONE.
    function automatic void expectTxn(int id, int a, int ta, int tg, int td, logic rdn,
                                      logic [7:0] ad, logic [7:0] wd, logic [7:0] rdB,
                                      logic [7:0] rdA, int nMax);
        int         tot;
        logic [7:0] rdEnd;
        tot   = ta + tg + td;
        rdEnd = rdn ? rdA : rdB;
        for (int i = 0; i <= tot + 1 && i < nMax; i++) begin
            if (i < ta)
                pushExp(id, a + i, mk(1'b1, ad, 1'b1, 1'b1, 1'b1, 1'b0, rdB));
            else if (i < ta + tg)
                pushExp(id, a + i, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, rdB));
            else if (i < tot)
                pushExp(id, a + i, mk(~rdn, rdn ? 8'h00 : wd, 1'b0, 1'b1, 1'b1, 1'b0, rdB));
            else if (i == tot)
                pushExp(id, a + i, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, rdEnd));
            else
                pushExp(id, a + i, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rdEnd));
        end
    endfunction

    function automatic void checkOne(int id, logic [20:0] got);
        exp_t e;
        if (id == 0) begin
            if (q0.size() == 0) return;
            e = q0[0];
        end else begin
            if (q1.size() == 0) return;
            e = q1[0];
        end
        if (e.cyc > cyc) return;
        if (id == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        nChecks++;
        if (e.cyc < cyc)
            $display("FAIL dut%0d missed_cycle %0d: checked at cycle %0d", id, e.cyc, cyc);
        else if (got !== e.v)
            $display("FAIL dut%0d outputs cycle %0d: got oe/out/sel/en/busy/done/rdata=%h required %h",
                     id, cyc, got, e.v);
        else
            nPass++;
    endfunction

    always @(negedge clkW) begin
        checkOne(0, {ad_oe, ad_out, ad_sel, en_tim, busy, done, rdata});
        checkOne(1, {ad_oe2, ad_out2, ad_sel2, en_tim2, busy2, done2, rdata2});
    end

    task automatic waitUntil(int c);
        while (cyc < c) @(negedge clkW);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a;
        resetW = 1'b1; req = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
        resetW2 = 1'b1; req2 = 1'b0; rw2 = 1'b0; addr2 = 8'h00; wdata2 = 8'h00; ad_in2 = 8'h00;
        repeat (3) @(negedge clkW);
        resetW = 1'b0;
        pushExp(0, cyc + 1, 21'd0);
        @(negedge clkW);

        // Write 0x45 to 0x21; inputs scrambled after acceptance
        addr = 8'h21; wdata = 8'h45; rw = 1'b0; req = 1'b1;
        a = cyc + 1;
        expectTxn(0, a, 10, 2, 10, 1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 99);
        @(negedge clkW);
        req = 1'b0; addr = 8'hFF; wdata = 8'h00; rw = 1'b1;
        waitUntil(a + 24);

        // Read 0x0C with stray req pulses in ADDR and DONE
        ad_in = 8'hEE; addr = 8'h0C; rw = 1'b1; req = 1'b1;
        a = cyc + 1;
        expectTxn(0, a, 10, 2, 10, 1'b1, 8'h0C, 8'h00, 8'h00, 8'h5A, 99);
        pushExp(0, a + 24, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A));
        @(negedge clkW);
        req = 1'b0; addr = 8'h55; rw = 1'b0;
        waitUntil(a + 4);
        req = 1'b1;
        @(negedge clkW);
        req = 1'b0;
        waitUntil(a + 11);
        ad_in = 8'h5A;
        waitUntil(a + 22);
        ad_in = 8'h33; req = 1'b1;
        @(negedge clkW);
        req = 1'b0;
        waitUntil(a + 25);

        // Write after read leaves rdata alone
        addr = 8'h7F; wdata = 8'h81; rw = 1'b0; req = 1'b1;
        a = cyc + 1;
        expectTxn(0, a, 10, 2, 10, 1'b0, 8'h7F, 8'h81, 8'h5A, 8'h5A, 99);
        @(negedge clkW);
        req = 1'b0;
        waitUntil(a + 24);

        // Read aborted by reset in its 15th cycle
        ad_in = 8'h99; addr = 8'h10; rw = 1'b1; req = 1'b1;
        a = cyc + 1;
        expectTxn(0, a, 10, 2, 10, 1'b1, 8'h10, 8'h00, 8'h5A, 8'h99, 15);
        @(negedge clkW);
        req = 1'b0;
        waitUntil(a + 14);
        resetW = 1'b1;
        pushExp(0, a + 15, 21'd0);
        pushExp(0, a + 16, 21'd0);
        @(negedge clkW);
        resetW = 1'b0;
        waitUntil(a + 17);

        // Fresh read after the abort
        addr = 8'h10; rw = 1'b1; req = 1'b1;
        a = cyc + 1;
        expectTxn(0, a, 10, 2, 10, 1'b1, 8'h10, 8'h00, 8'h00, 8'h99, 99);
        @(negedge clkW);
        req = 1'b0;
        waitUntil(a + 24);

        // req and reset on the same edge
        req = 1'b1; resetW = 1'b1;
        pushExp(0, cyc + 1, 21'd0);
        @(negedge clkW);
        req = 1'b0; resetW = 1'b0;
        pushExp(0, cyc + 1, 21'd0);
        @(negedge clkW);
        @(negedge clkW);

        // Minimal timing with req held high: back-to-back transactions
        resetW2 = 1'b0; req2 = 1'b1; addr2 = 8'h3C; wdata2 = 8'hC3; rw2 = 1'b0;
        a = cyc + 1;
        expectTxn(1, a, 1, 1, 1, 1'b0, 8'h3C, 8'hC3, 8'h00, 8'h00, 99);
        expectTxn(1, a + 5, 1, 1, 1, 1'b0, 8'h3C, 8'hC3, 8'h00, 8'h00, 99);
        waitUntil(a + 9);
        req2 = 1'b0;
        waitUntil(a + 12);

        foreach (q0[i]) begin
            nChecks++;
            $display("FAIL dut0 unchecked_cycle %0d: never compared, last cycle %0d", q0[i].cyc, cyc);
        end
        foreach (q1[i]) begin
            nChecks++;
            $display("FAIL dut1 unchecked_cycle %0d: never compared, last cycle %0d", q1[i].cyc, cyc);
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
